// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bundle between a datapath master and alu_seq
//
// Ports carried (master view):
//   in_valid  out  operation request
//   in_ready  in   ALU can accept a request
//   s         out  4-bit opcode
//   a, b      out  WIDTH-bit operands
//   out_valid in   result available
//   out_ready out  consumer accepts result
//   y         in   WIDTH+1-bit result, bit WIDTH is carry/extension
//   zero      in   y[WIDTH-1:0] == 0
//   neg       in   y[WIDTH-1]
//   err       in   illegal opcode was issued
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       s;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   y;
  logic             zero;
  logic             neg;
  logic             err;

  modport master (
    output in_valid, s, a, b, out_ready,
    input  in_ready, out_valid, y, zero, neg, err
  );

  modport slave (
    input  in_valid, s, a, b, out_ready,
    output in_ready, out_valid, y, zero, neg, err
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with valid/ready handshakes and status flags
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_if.slave: in_valid/in_ready/s/a/b request side,
//          out_valid/out_ready/y/zero/neg/err result side
//
// Optional feature: define ALU_SEQ_MUL_EN to build opcode 0111 as an iterative
// shift-add multiply (WIDTH BUSY cycles). Without it, 0111 is an illegal opcode.
//
// Opcodes: 0000 AND, 0001 NOR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 SHL,
//          0110 SHR, 0111 MUL (optional), 1000-1111 illegal.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int SH_W = CNT_W - 1;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_live;
  logic [WIDTH:0]   r_y;
  logic             r_zero;
  logic             r_neg;
  logic             r_err;

  logic             w_accept;
  logic             w_load;
  logic [WIDTH:0]   w_res;
  logic             w_err;
  logic [WIDTH:0]   w_op_res;
  logic             w_op_ill;
  logic [SH_W-1:0]  w_sh;

  // r_live keeps in_ready low through reset and for no longer than the
  // first clock after release.
  assign bus.in_ready  = r_live && (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.y         = r_y;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.err       = r_err;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_sh     = bus.b[SH_W-1:0];

  // Single-cycle result decode straight from the request operands.
  // Shifts of WIDTH or more (non power-of-two WIDTH only) drop out as zero.
  always_comb begin
    w_op_res = '0;
    w_op_ill = 1'b0;
    case (bus.s)
      4'b0000: w_op_res = {1'b0, bus.a & bus.b};
      4'b0001: w_op_res = {1'b0, ~(bus.a | bus.b)};
      4'b0010: w_op_res = {1'b0, bus.a} + {1'b0, bus.b};
      4'b0011: w_op_res = {1'b0, bus.a ^ bus.b};
      // Carry out of a + ~b + 1 is the "no borrow" flag, i.e. a >= b.
      4'b0100: w_op_res = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
      4'b0101: w_op_res = {1'b0, bus.a << w_sh};
      4'b0110: w_op_res = {1'b0, bus.a >> w_sh};
`ifdef ALU_SEQ_MUL_EN
      4'b0111: w_op_res = '0;
`endif
      default: w_op_ill = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_prod_step;
  logic               w_mul_start;
  logic               w_mul_last;

  assign w_mul_start = w_accept && (bus.s == 4'b0111);
  assign w_mul_last  = (r_state == S_BUSY) && (r_cnt == CNT_W'(WIDTH - 1));
  // One multiplier bit per cycle, LSB first; the multiplicand walks left.
  assign w_prod_step = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_mul_start) begin
      r_prod   <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, bus.a};
      r_mplier <= bus.b;
      r_cnt    <= '0;
    end else if (r_state == S_BUSY) begin
      r_prod   <= w_prod_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_res       = '0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (bus.s == 4'b0111) w_state_nxt = S_BUSY;
          else
`endif
          begin
            w_state_nxt = S_DONE;
            w_load      = 1'b1;
            w_res       = w_op_ill ? '0 : w_op_res;
            w_err       = w_op_ill;
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: begin
        if (w_mul_last) begin
          w_state_nxt = S_DONE;
          w_load      = 1'b1;
          // Bit WIDTH flags a non-zero upper product half.
          w_res       = {|w_prod_step[2*WIDTH-1:WIDTH], w_prod_step[WIDTH-1:0]};
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_y     <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_load) begin
        r_y    <= w_res;
        r_zero <= (w_res[WIDTH-1:0] == '0);
        r_neg  <= w_res[WIDTH-1];
        r_err  <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=16)
module tb_alu_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic        exp_set = 1'b0;
  logic [16:0] exp_y   = '0;
  logic        exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference behaviour from plain integer arithmetic; returns {err, y}.
  function automatic logic [17:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned      ua, ub, sh;
    longint unsigned  p;
    logic [16:0]      y;
    logic             e;
    ua = a;
    ub = b;
    sh = ub % 16;
    y  = '0;
    e  = 1'b0;
    case (op)
      4'd0: y = 17'(ua & ub);
      4'd1: y = 17'(~(ua | ub) & 32'hFFFF);
      4'd2: y = 17'(ua + ub);
      4'd3: y = 17'(ua ^ ub);
      4'd4: begin
        y[15:0] = 16'((ua - ub) & 32'hFFFF);
        y[16]   = (ua >= ub);
      end
      4'd5: y = 17'((ua << sh) & 32'hFFFF);
      4'd6: y = 17'(ua >> sh);
      4'd7: begin
        if (MUL_EN) begin
          p       = longint'(ua) * longint'(ub);
          y[15:0] = 16'(p % 65536);
          y[16]   = (p >= 65536);
        end else begin
          e = 1'b1;
        end
      end
      default: e = 1'b1;
    endcase
    return {e, y};
  endfunction

  // Every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (!exp_set) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        chk("y",    32'(bus.y),    32'(exp_y));
        chk("err",  32'(bus.err),  32'(exp_err));
        chk("zero", 32'(bus.zero), 32'(exp_y[15:0] == 16'h0));
        chk("neg",  32'(bus.neg),  32'(exp_y[15]));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] aa, input logic [15:0] bb,
                       input int stall, input logic [16:0] lit_y);
    logic [17:0] m;
    int          lat;
    int          want_lat;
    @(posedge clk); #1;
    chk("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.s        = op;
    bus.a        = aa;
    bus.b        = bb;
    bus.in_valid = 1'b1;
    @(posedge clk);
    m       = model(op, aa, bb);
    exp_y   = m[16:0];
    exp_err = m[17];
    exp_set = 1'b1;
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~aa;
    bus.b        = bb + 16'd1;
    bus.s        = ~op;
    want_lat = (op == 4'b0111 && MUL_EN) ? 17 : 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 100);
    chk("latency", 32'(lat), 32'(want_lat));
    chk("result_literal", 32'(bus.y), 32'(lit_y));
    repeat (stall) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.s        = 4'b0011;
      bus.a        = 16'hFFFF;
      bus.b        = 16'h1234;
      @(negedge clk);
      chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    exp_set = 1'b0;
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_handshake", 32'({bus.in_ready, bus.out_valid}), 32'b10);
  endtask

  task automatic reset_mid(input logic [3:0] op, input logic [15:0] aa, input logic [15:0] bb);
    logic [17:0] m;
    @(posedge clk); #1;
    bus.s        = op;
    bus.a        = aa;
    bus.b        = bb;
    bus.in_valid = 1'b1;
    @(posedge clk);
    m       = model(op, aa, bb);
    exp_y   = m[16:0];
    exp_err = m[17];
    exp_set = 1'b1;
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    exp_set = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_y",         32'(bus.y),         32'd0);
    chk("rst_flags",     32'({bus.zero, bus.neg, bus.err}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_y",        32'(bus.y),        32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_out_after_reset", 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.s         = '0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (2) @(negedge clk);
    chk("reset_in_ready",  32'(bus.in_ready),  32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_y",         32'(bus.y),         32'd0);
    chk("reset_flags",     32'({bus.zero, bus.neg, bus.err}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("first_in_ready_high", 32'(bus.in_ready), 32'd1);

    issue(4'b0010, 16'hFFFF, 16'h0001, 0, 17'h10000);
    issue(4'b0010, 16'h1234, 16'h4321, 0, 17'h05555);
    issue(4'b0100, 16'h0000, 16'h0001, 0, 17'h0FFFF);
    issue(4'b0100, 16'h0005, 16'h0003, 0, 17'h10002);
    issue(4'b0100, 16'h1234, 16'h1234, 0, 17'h10000);
    issue(4'b0000, 16'h00F0, 16'h0FF0, 5, 17'h000F0);
    issue(4'b0001, 16'h0000, 16'h0000, 0, 17'h0FFFF);
    issue(4'b0011, 16'h00FF, 16'h0F0F, 1, 17'h00FF0);
    issue(4'b1010, 16'h1111, 16'h2222, 0, 17'h00000);
    issue(4'b1111, 16'hFFFF, 16'hFFFF, 0, 17'h00000);
    issue(4'b0101, 16'h0001, 16'd15,   0, 17'h08000);
    issue(4'b0101, 16'h0001, 16'h0013, 0, 17'h00008);
    issue(4'b0110, 16'h8000, 16'd4,    0, 17'h00800);
`ifdef ALU_SEQ_MUL_EN
    issue(4'b0111, 16'h0100, 16'h0100, 0, 17'h10000);
    issue(4'b0111, 16'h0007, 16'h0009, 0, 17'h0003F);
    issue(4'b0111, 16'hFFFF, 16'hFFFF, 2, 17'h10001);
    reset_mid(4'b0111, 16'h0003, 16'h0005);
`else
    issue(4'b0111, 16'h0007, 16'h0009, 0, 17'h00000);
    reset_mid(4'b0000, 16'h0005, 16'h0003);
`endif
    issue(4'b0010, 16'h0001, 16'h0002, 0, 17'h00003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 16-bit combinational ALU.
- Adds:
  - generic WIDTH
  - valid/ready handshakes on input and output
  - status flags
  - SUB and shift ops
  - an iterative multi-cycle multiply
- Sits between the datapath register file and writeback.
- One operation in flight at a time.

Parameters:
- WIDTH, 16, operand width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the internal multiply iteration counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- s  input  4  opcode
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- y  output  WIDTH+1  result; bit WIDTH is carry/extension
- zero  output  1  y[WIDTH-1:0]==0
- neg  output  1  y[WIDTH-1]
- err  output  1  illegal opcode was issued

Behaviour:
- Reset:
  - asynchronous on rst_n low
  - state=IDLE; y=0, zero=0, neg=0, err=0, out_valid=0, in_ready=0 while rst_n low
  - in_ready=1 from the first clock after release
  - reset mid-operation aborts the operation with no output
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept: in_valid & in_ready at a rising edge latches s, a, b.
- Single-cycle ops go IDLE->DONE; the result is registered, so out_valid rises one cycle after accept.
  - 0000 AND: y = {0, a&b}
  - 0001 NOR: y = {0, ~(a|b)}
  - 0010 ADD: y = a+b, zero-extended; y[WIDTH] = carry out
  - 0011 XOR: y = {0, a^b}
  - 0100 SUB: y = a + ~b + 1; y[WIDTH] = 1 iff a>=b unsigned
  - 0101 SHL: y = {0, a << b[CNT_W-2:0]}
  - 0110 SHR: logical; y = {0, a >> b[CNT_W-2:0]}
- 0111 MUL (see optional feature):
  - IDLE->BUSY; shift-add, one multiplier bit per cycle, exactly WIDTH BUSY cycles, then DONE.
  - out_valid rises WIDTH+1 cycles after accept.
  - y[WIDTH-1:0] = low half of the product; y[WIDTH] = 1 iff the high half is nonzero.
- Illegal opcodes 1000-1111:
  - IDLE->DONE, y=0, err=1.
  - err is 0 for every legal op.
- Flags are registered with y and always computed from y.
- DONE holds y, flags and err stable until out_valid & out_ready, then goes to IDLE.
  - No back-to-back issue: minimum issue interval is 2 cycles for single-cycle ops.
- in_valid is ignored while in BUSY or DONE; a/b/s changes there do not affect the result.
- Shift amounts >= WIDTH are possible only when WIDTH is not a power of two; they yield y=0.
- Wrap-around:
  - ADD 0xFFFF+0x0001 -> y=0x1_0000, zero=1.
  - SUB 0x0000-0x0001 -> y[15:0]=0xFFFF, y[16]=0, neg=1.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: opcode 0111 is MUL as above, with the BUSY state, iteration counter and 2*WIDTH product register.
- Undefined:
  - no BUSY state or multiply logic is synthesised.
  - 0111 is treated as illegal: DONE after 1 cycle, y=0, err=1.

Test Plan:
- Reset: rst_n low mid-MUL (WIDTH=16, a=3, b=5, issued 4 cycles earlier), released -> out_valid never asserts for that op; y=0, in_ready=1 one cycle after release.
- ADD carry: a=0xFFFF, b=0x0001, s=0010 -> one cycle later out_valid=1, y=0x10000, zero=1, neg=0, err=0.
- SUB borrow: a=0x0000, b=0x0001, s=0100 -> y=0x0FFFF, neg=1. Then a=0x0005, b=0x0003 -> y=0x10002.
- Backpressure: AND a=0x00F0, b=0x0FF0 with out_ready=0 for 5 cycles -> y=0x000F0 held stable, in_ready=0; new in_valid with s=0011 is ignored. out_ready=1 -> IDLE next cycle.
- MUL (macro on): a=0x0100, b=0x0100 -> out_valid exactly 17 cycles after accept; y[15:0]=0x0000, y[16]=1, zero=1. a=7, b=9 -> y=0x0003F. Macro off: s=0111 -> err=1, y=0 after 1 cycle.
- Illegal and shift ops: s=1010 -> err=1, y=0. SHL a=0x0001, b=15 -> y=0x08000, neg=1. SHR a=0x8000, b=4 -> y=0x00800.
